cn_minsum_serial: RTL and testbench

Serial check-node processor for the LDPC reconciliation decoder. It is the counterpart of the variable-node update: it accepts the DEG variable-to-check messages of one parity check, one per cycle. It then returns the DEG check-to-variable messages, computed with offset min-sum, in the same edge order, plus the check's parity (syndrome) bit. All messages use the decoder's signed two's-complement fixed-point format with INT integer and FRAC fractional bits.

---
 rtl/cn_minsum_serial.sv | 166 ++++++++++++++++
 tb/tb_cn_minsum_serial.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/cn_minsum_serial.sv
// Serial offset min-sum check-node processor: collects DEG messages, then emits
// DEG extrinsic check-to-variable messages in edge order, plus the parity bit.
module cn_minsum_serial #(
  parameter int unsigned INT    = 8,
  parameter int unsigned FRAC   = 8,
  parameter int unsigned DEG    = 6,
  parameter int unsigned OFFSET = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INT+FRAC-1:0]   in_msg,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [INT+FRAC-1:0]   out_msg,
  output logic                  out_last,
  output logic                  parity_ok
);

  localparam int unsigned W  = INT + FRAC;
  localparam int unsigned M  = W - 1;
  localparam int unsigned CW = (DEG > 1) ? $clog2(DEG) : 1;

  localparam logic [M-1:0]  MAG_MAX = '1;
  localparam logic [M-1:0]  OFF     = M'(OFFSET);
  localparam logic [CW-1:0] LAST    = CW'(DEG - 1);

  typedef enum logic {COLLECT, EMIT} state_t;

  state_t         state_q, state_d;
  logic [DEG-1:0] sign_q, sign_d;
  logic [M-1:0]   min1_q, min1_d;
  logic [M-1:0]   min2_q, min2_d;
  logic [CW-1:0]  idx_q, idx_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           sgn_q, sgn_d;

  logic           in_ready_q, in_ready_d;
  logic           out_valid_q, out_valid_d;
  logic [W-1:0]   out_msg_q, out_msg_d;
  logic           out_last_q, out_last_d;
  logic           parity_q, parity_d;

  logic [W-1:0]   neg_in;
  logic [M-1:0]   in_mag;
  logic [M-1:0]   sel_mag;
  logic [M-1:0]   emit_mag;
  logic [W-1:0]   emit_val;
  logic           emit_neg;

  // Most-negative input has no positive counterpart; saturate to the max magnitude.
  always_comb begin
    neg_in = -in_msg;
    if (in_msg[W-1]) begin
      in_mag = neg_in[W-1] ? MAG_MAX : neg_in[M-1:0];
    end else begin
      in_mag = in_msg[M-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    min1_d  = min1_q;
    min2_d  = min2_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;

    unique case (state_q)
      COLLECT: begin
        if (in_valid) begin
          sign_d[cnt_q] = in_msg[W-1];
          sgn_d         = sgn_q ^ in_msg[W-1];
          if (in_mag < min1_q) begin
            min2_d = min1_q;
            min1_d = in_mag;
            idx_d  = cnt_q;
          end else if (in_mag < min2_q) begin
            min2_d = in_mag;
          end
          if (cnt_q == LAST) begin
            state_d = EMIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (cnt_q == LAST) begin
            state_d = COLLECT;
            sign_d  = '0;
            min1_d  = MAG_MAX;
            min2_d  = MAG_MAX;
            idx_d   = '0;
            cnt_d   = '0;
            sgn_d   = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // The output register is loaded from next-state values so edge 0 is ready
  // the cycle after the last accept, and holds naturally under back-pressure.
  always_comb begin
    sel_mag  = (cnt_d == idx_d) ? min2_d : min1_d;
    emit_mag = (sel_mag > OFF) ? (sel_mag - OFF) : '0;
    emit_neg = sgn_d ^ sign_d[cnt_d];
    emit_val = {1'b0, emit_mag};

    in_ready_d  = (state_d == COLLECT);
    out_valid_d = (state_d == EMIT);
    out_last_d  = 1'b0;
    out_msg_d   = '0;
    parity_d    = 1'b0;
    if (state_d == EMIT) begin
      out_last_d = (cnt_d == LAST);
      parity_d   = ~sgn_d;
      out_msg_d  = (emit_neg && (emit_mag != '0)) ? -emit_val : emit_val;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      sign_q      <= '0;
      min1_q      <= MAG_MAX;
      min2_q      <= MAG_MAX;
      idx_q       <= '0;
      cnt_q       <= '0;
      sgn_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_msg_q   <= '0;
      out_last_q  <= 1'b0;
      parity_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      min1_q      <= min1_d;
      min2_q      <= min2_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      sgn_q       <= sgn_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_msg_q   <= out_msg_d;
      out_last_q  <= out_last_d;
      parity_q    <= parity_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_msg   = out_msg_q;
  assign out_last  = out_last_q;
  assign parity_ok = parity_q;

endmodule

// File: tb/tb_cn_minsum_serial.sv
// Bench for cn_minsum_serial: two instances (OFFSET 0 and 0x40) share stimulus;
// expectations come from spec constants or an extrinsic min-over-others model.
module tb_cn_minsum_serial;

  localparam int W   = 16;
  localparam int DEG = 4;

  typedef logic [W-1:0] frame_t [DEG];

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] in_msg;
  logic         out_ready;

  logic         in_ready0, out_valid0, out_last0, par0;
  logic [W-1:0] out_msg0;
  logic         in_ready1, out_valid1, out_last1, par1;
  logic [W-1:0] out_msg1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cn_minsum_serial #(.INT(8), .FRAC(8), .DEG(DEG), .OFFSET(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_msg(in_msg), .out_valid(out_valid0), .out_ready(out_ready),
    .out_msg(out_msg0), .out_last(out_last0), .parity_ok(par0)
  );

  cn_minsum_serial #(.INT(8), .FRAC(8), .DEG(DEG), .OFFSET(16'h0040)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_msg(in_msg), .out_valid(out_valid1), .out_ready(out_ready),
    .out_msg(out_msg1), .out_last(out_last1), .parity_ok(par1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Extrinsic min-sum: edge j sees the min magnitude and sign product of all other edges.
  function automatic void model(input frame_t x, input int off, output frame_t y, output logic par);
    int m, v;
    bit neg;
    par = 1'b1;
    for (int k = 0; k < DEG; k++) par ^= x[k][W-1];
    for (int j = 0; j < DEG; j++) begin
      m = 32767;
      neg = 1'b0;
      for (int k = 0; k < DEG; k++) begin
        if (k != j) begin
          v = int'($signed(x[k]));
          if (v < 0) v = -v;
          if (v > 32767) v = 32767;
          if (v < m) m = v;
          neg ^= x[k][W-1];
        end
      end
      m = m - off;
      if (m < 0) m = 0;
      y[j] = neg ? W'(-m) : W'(m);
    end
  endfunction

  task automatic run_frame(input string tag, input frame_t x,
                           input frame_t e0, input logic p0,
                           input frame_t e1, input logic p1,
                           input bit gaps, input int bp_edge, input int bp_cyc);
    for (int k = 0; k < DEG; k++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 2);
        repeat (g) begin
          in_valid = 1'b0;
          in_msg   = W'($urandom);
          step();
          chk($sformatf("%s/gap_out_valid", tag), out_valid0, 1'b0);
        end
      end
      chk($sformatf("%s/in_ready0_k%0d", tag, k), in_ready0, 1'b1);
      chk($sformatf("%s/in_ready1_k%0d", tag, k), in_ready1, 1'b1);
      chk($sformatf("%s/out_valid_k%0d", tag, k), out_valid0, 1'b0);
      in_valid = 1'b1;
      in_msg   = x[k];
      step();
    end
    in_valid = 1'b0;
    for (int j = 0; j < DEG; j++) begin
      if (j == bp_edge) begin
        out_ready = 1'b0;
        repeat (bp_cyc) begin
          in_valid = 1'b1;
          in_msg   = W'($urandom);
          step();
          chk($sformatf("%s/bp_valid%0d", tag, j), out_valid0, 1'b1);
          chk($sformatf("%s/bp_msg0_%0d", tag, j), out_msg0, e0[j]);
          chk($sformatf("%s/bp_msg1_%0d", tag, j), out_msg1, e1[j]);
          chk($sformatf("%s/bp_par0_%0d", tag, j), par0, p0);
          chk($sformatf("%s/bp_in_ready%0d", tag, j), in_ready0, 1'b0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      chk($sformatf("%s/out_valid0_%0d", tag, j), out_valid0, 1'b1);
      chk($sformatf("%s/out_valid1_%0d", tag, j), out_valid1, 1'b1);
      chk($sformatf("%s/msg0_%0d", tag, j), out_msg0, e0[j]);
      chk($sformatf("%s/msg1_%0d", tag, j), out_msg1, e1[j]);
      chk($sformatf("%s/last0_%0d", tag, j), out_last0, (j == DEG-1));
      chk($sformatf("%s/last1_%0d", tag, j), out_last1, (j == DEG-1));
      chk($sformatf("%s/par0_%0d", tag, j), par0, p0);
      chk($sformatf("%s/par1_%0d", tag, j), par1, p1);
      chk($sformatf("%s/emit_in_ready_%0d", tag, j), in_ready0, 1'b0);
      step();
    end
    chk($sformatf("%s/in_ready0_after", tag), in_ready0, 1'b1);
    chk($sformatf("%s/in_ready1_after", tag), in_ready1, 1'b1);
    chk($sformatf("%s/out_valid_after", tag), out_valid0, 1'b0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "/in_ready0"}, in_ready0, 1'b1);
    chk({tag, "/in_ready1"}, in_ready1, 1'b1);
    chk({tag, "/out_valid0"}, out_valid0, 1'b0);
    chk({tag, "/out_valid1"}, out_valid1, 1'b0);
    chk({tag, "/out_msg0"}, out_msg0, 16'h0000);
    chk({tag, "/out_last0"}, out_last0, 1'b0);
    chk({tag, "/parity0"}, par0, 1'b0);
  endtask

  initial begin
    frame_t x1, e1_0, e1_1, x2, e2_0, x3, e3_1, x6, e6_0;
    frame_t xr, m0, m1;
    logic   mp0, mp1;

    x1   = '{16'h0100, 16'hFE00, 16'h0300, 16'h0080};
    e1_0 = '{16'hFF80, 16'h0080, 16'hFF80, 16'hFF00};
    e1_1 = '{16'hFFC0, 16'h0040, 16'hFFC0, 16'hFF40};
    x2   = '{16'h8000, 16'h8000, 16'h8000, 16'h8000};
    e2_0 = '{16'h8001, 16'h8001, 16'h8001, 16'h8001};
    x3   = '{16'h0020, 16'h0020, 16'h0020, 16'h0020};
    e3_1 = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    x6   = '{16'h0200, 16'h0200, 16'hFF00, 16'hFF00};
    e6_0 = '{16'h0100, 16'h0100, 16'hFF00, 16'hFF00};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_msg    = '0;
    out_ready = 1'b1;
    step();
    step();
    chk_reset("reset");
    rst_n = 1'b1;

    // Basic frame and offset variant
    run_frame("basic", x1, e1_0, 1'b0, e1_1, 1'b0, 1'b0, -1, 0);

    // Saturation and ties
    model(x2, 64, m1, mp1);
    run_frame("sat", x2, e2_0, 1'b1, m1, mp1, 1'b0, -1, 0);

    // Offset clamping to zero
    model(x3, 0, m0, mp0);
    run_frame("clamp", x3, m0, mp0, e3_1, 1'b1, 1'b0, -1, 0);

    // Back-pressure on edge 1
    run_frame("bp", x1, e1_0, 1'b0, e1_1, 1'b0, 1'b0, 1, 3);

    // Reset mid-frame
    in_valid = 1'b1;
    in_msg   = 16'h0100;
    step();
    in_msg   = 16'hFE00;
    step();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    step();
    chk_reset("midreset");
    rst_n = 1'b1;
    run_frame("after_reset", x1, e1_0, 1'b0, e1_1, 1'b0, 1'b0, -1, 0);

    // Back-to-back with random gaps
    run_frame("b2b_a", x1, e1_0, 1'b0, e1_1, 1'b0, 1'b1, -1, 0);
    model(x6, 64, m1, mp1);
    run_frame("b2b_b", x6, e6_0, 1'b1, m1, mp1, 1'b1, -1, 0);

    // Randomized frames
    for (int f = 0; f < 25; f++) begin
      for (int k = 0; k < DEG; k++) begin
        case ($urandom_range(0, 5))
          0:       xr[k] = 16'h8000;
          1:       xr[k] = 16'h0000;
          2:       xr[k] = W'($urandom_range(0, 255));
          3:       xr[k] = W'(-int'($urandom_range(0, 255)));
          default: xr[k] = W'($urandom);
        endcase
      end
      model(xr, 0, m0, mp0);
      model(xr, 64, m1, mp1);
      run_frame($sformatf("rnd%0d", f), xr, m0, mp0, m1, mp1, 1'b1,
                int'($urandom_range(0, DEG)), int'($urandom_range(1, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
